max7219_digit_writer: RTL

- Downstream consumer of the binary-to-BCD stage.
- Latches six BCD digits (HH:MM:SS) plus decimal-point flags on a refresh strobe and serialises them as 16-bit frames to a MAX7219 driver running in Code-B decode mode.
- On the first refresh after reset it sends the MAX7219 initialisation frames before the digit frames.
- Sits between the clock/BCD datapath and the chip output pins.

---
 rtl/max7219_digit_writer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/max7219_digit_writer.sv
// Serialises six latched BCD digits and their decimal points as 16-bit MAX7219 frames.
// On the first refresh after reset, the chip initialisation frames are sent before the digit frames.
module max7219_digit_writer #(
  parameter int          SCLK_DIV  = 4,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_stb,
  input  logic [23:0] i_bcd_digits,
  input  logic [5:0]  i_dp,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_serial_din,
  output logic        o_serial_clk,
  output logic        o_serial_load
);

  // Handshake: a request is taken only in IDLE, on a rising edge where i_stb and i_en
  // are both high. No requests are queued. o_busy covers the transfer, and o_done pulses
  // for one cycle after the last frame is latched.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    LATCH   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0] DIV_LAST    = 4'(SCLK_DIV - 1);
  localparam logic [3:0] LAST_INIT   = 4'd4;
  localparam logic [3:0] FIRST_DIGIT = 4'd5;
  localparam logic [3:0] LAST_FRAME  = 4'd10;
  localparam logic [3:0] LAST_BIT    = 4'd15;

  state_t      state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  frame_q, frame_d;
  logic [15:0] sreg_q, sreg_d;
  logic        init_q, init_d;
  logic [23:0] digits_q, digits_d;
  logic [5:0]  dp_q, dp_d;
  logic        div_last;
  logic        shifting_d;

  // Frame indices 0..4 are the init frames; indices 5..10 carry digits 1..6.
  function automatic logic [15:0] frame_word(input logic [3:0] idx,
                                             input logic [23:0] digits,
                                             input logic [5:0] dp);
    logic [3:0] addr;
    logic [2:0] k;
    addr = idx - 4'd4;
    k    = 3'(idx - 4'd5);
    case (idx)
      4'd0:    frame_word = 16'h0C01;
      4'd1:    frame_word = 16'h09FF;
      4'd2:    frame_word = {8'h0A, 4'h0, INTENSITY};
      4'd3:    frame_word = 16'h0B05;
      4'd4:    frame_word = 16'h0F00;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:
        frame_word = {4'h0, addr, dp[k], 3'b000, digits[{k, 2'b00} +: 4]};
      default: frame_word = 16'h0000;
    endcase
  endfunction

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    sreg_d   = sreg_q;
    init_d   = init_q;
    digits_d = digits_q;
    dp_d     = dp_q;
    // Every timed state lasts exactly SCLK_DIV cycles, so one divider serves all of them.
    div_d = ((state_q inside {SETUP, SCLK_HI, SCLK_LO, LATCH}) && !div_last)
            ? div_q + 4'd1 : 4'd0;

    case (state_q)
      IDLE: begin
        if (i_stb && i_en) begin
          state_d  = SETUP;
          digits_d = i_bcd_digits;
          dp_d     = i_dp;
          bit_d    = 4'd0;
          frame_d  = init_q ? FIRST_DIGIT : 4'd0;
          sreg_d   = frame_word(frame_d, i_bcd_digits, i_dp);
        end
      end
      SETUP: begin
        if (div_last) state_d = SCLK_HI;
      end
      SCLK_HI: begin
        if (div_last) begin
          state_d = SCLK_LO;
          sreg_d  = {sreg_q[14:0], 1'b0};
        end
      end
      SCLK_LO: begin
        if (div_last) begin
          if (bit_q == LAST_BIT) begin
            state_d = LATCH;
            bit_d   = 4'd0;
          end else begin
            state_d = SCLK_HI;
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      LATCH: begin
        if (div_last) begin
          if (frame_q == LAST_INIT) init_d = 1'b1;
          if (frame_q == LAST_FRAME) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            frame_d = frame_q + 4'd1;
            sreg_d  = frame_word(frame_d, digits_q, dp_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        frame_d = 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign shifting_d = (state_d inside {SETUP, SCLK_HI, SCLK_LO});

  // Pin outputs are registered from the next state so the chip never sees decode glitches.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      div_q         <= 4'd0;
      bit_q         <= 4'd0;
      frame_q       <= 4'd0;
      sreg_q        <= 16'h0000;
      init_q        <= 1'b0;
      digits_q      <= 24'h000000;
      dp_q          <= 6'b000000;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_serial_din  <= 1'b0;
      o_serial_clk  <= 1'b0;
      o_serial_load <= 1'b1;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      frame_q       <= frame_d;
      sreg_q        <= sreg_d;
      init_q        <= init_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      o_busy        <= (state_d inside {SETUP, SCLK_HI, SCLK_LO, LATCH});
      o_done        <= (state_d == DONE);
      o_serial_din  <= shifting_d ? sreg_d[15] : 1'b0;
      o_serial_clk  <= (state_d == SCLK_HI);
      o_serial_load <= !shifting_d;
    end
  end

endmodule
